// File: rtl/fifo_csr_param_if.sv
// fifo_csr_param_if: CSR push port, consumer pop port and status outputs of fifo_csr_param
interface fifo_csr_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              csr_enable;
  logic [11:0]       csr_addr;
  logic [2:0]        csr_op;
  logic [31:0]       rs1_data;
  logic [4:0]        rs1_zimm;
  logic              next;
  logic [DATA_W-1:0] data;
  logic              have_next;
  logic              full;
  logic [CW-1:0]     count;
  logic [31:0]       csr_data_out;
  modport master (
    output csr_enable, csr_addr, csr_op, rs1_data, rs1_zimm, next,
    input  data, have_next, full, count, csr_data_out
  );
  modport slave (
    input  csr_enable, csr_addr, csr_op, rs1_data, rs1_zimm, next,
    output data, have_next, full, count, csr_data_out
  );
endinterface

// File: rtl/fifo_csr_param.sv
// fifo_csr_param: FIFO filled by CSR writes, drained by a first-word-fall-through consumer port.
// Define FIFO_CSR_STATUS_EN to add the status register with sticky overflow flag.
module fifo_csr_param #(
  parameter int          DATA_W      = 8,
  parameter int          DEPTH       = 16,
  parameter logic [11:0] DATA_ADDR   = 12'h51,
  parameter logic [11:0] STATUS_ADDR = 12'h52
) (
  input logic             clk_i,
  input logic             reset_ni,
  fifo_csr_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] OP_RW  = 3'd1;
  localparam logic [2:0] OP_RC  = 3'd3;
  localparam logic [2:0] OP_RWI = 3'd5;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       zext, cnt_ext, status;
  logic [DATA_W-1:0] wval;
  logic              push_req, push, pop, is_full, not_empty, drop, stat_sel;
  assign zext      = {27'b0, bus.rs1_zimm};
  assign cnt_ext   = 32'(cnt_q);
  assign not_empty = cnt_q != '0;
  assign is_full   = cnt_q == CW'(DEPTH);
  assign push_req  = bus.csr_enable && bus.csr_addr == DATA_ADDR &&
                     (bus.csr_op == OP_RW || bus.csr_op == OP_RWI);
  assign wval      = bus.csr_op == OP_RWI ? zext[DATA_W-1:0] : bus.rs1_data[DATA_W-1:0];
  assign pop       = bus.next && not_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push      = push_req && (!is_full || pop);
  assign drop      = push_req && is_full && !pop;
  assign stat_sel  = bus.csr_enable && bus.csr_addr == STATUS_ADDR;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= wval;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
`ifdef FIFO_CSR_STATUS_EN
  logic ovf_q;
  logic ovf_clr;
  assign ovf_clr = stat_sel && bus.csr_op == OP_RC && bus.rs1_data[31];
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) ovf_q <= 1'b0;
    else ovf_q <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
  end
  assign status = {ovf_q, 15'b0, is_full, not_empty, 3'b0, cnt_ext[10:0]};
`else
  assign status = 32'b0;
`endif
  assign bus.data         = mem_q[rd_q];
  assign bus.have_next    = not_empty;
  assign bus.full         = is_full;
  assign bus.count        = cnt_q;
  assign bus.csr_data_out = stat_sel ? status : 32'b0;
  logic unused_ok;
  assign unused_ok = ^{bus.rs1_data, zext, cnt_ext, drop};
endmodule

// File: doc/fifo_csr_param.md
FIFO_CSR_PARAM -- requirements
Module: fifo_csr_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, FIFO entry width (1..32).
REQ-002 SHALL provide parameter DEPTH, default 16, entry count (power of two, 2..1024).
REQ-003 SHALL provide parameter DATA_ADDR, default 'h51, CSR address of the push port.
REQ-004 SHALL provide parameter STATUS_ADDR, default 'h52, CSR address of the status register.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port csr_enable  input  1  CSR access strobe, one access per cycle.
REQ-008 SHALL have port csr_addr  input  CsrAddrT  CSR address.
REQ-009 SHALL have port csr_op  input  csr_op_t  CSR operation (CSRRW/S/C, CSRRWI/SI/CI).
REQ-010 SHALL have port rs1_data  input  word  register source operand.
REQ-011 SHALL have port rs1_zimm  input  r  5-bit immediate or rs1 index.
REQ-012 SHALL have port next  input  1  consumer pop request.
REQ-013 SHALL have port data  output  DATA_W  head entry (first-word fall-through).
REQ-014 SHALL have port have_next  output  1  FIFO non-empty.
REQ-015 SHALL have port full  output  1  count == DEPTH.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port csr_data_out  output  word  CSR read data.

Function
REQ-018 Push SHALL occur when csr_enable=1, csr_addr==DATA_ADDR, and csr_op is CSRRW (value rs1_data[DATA_W-1:0]) or CSRRWI (value zero-extended rs1_zimm, truncated to DATA_W).
REQ-019 CSRRS/CSRRC/CSRRSI/CSRRCI to DATA_ADDR SHALL NOT push.
REQ-020 Pop SHALL occur on a rising edge with next=1 and have_next=1; next with have_next=0 SHALL be ignored.
REQ-021 data SHALL equal the oldest entry combinationally from storage (zero latency); pushed value SHALL appear on data the cycle after its push edge if FIFO was empty.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits wrapping modulo DEPTH; count SHALL be a separate register, +1 push, -1 pop, unchanged for both or neither.
REQ-023 Push while full without simultaneous pop SHALL be dropped, storage and pointers unchanged.
REQ-024 Push while full with simultaneous pop SHALL be accepted; count stays DEPTH.
REQ-025 Push while empty with next=1 SHALL push only; count becomes 1.
REQ-026 csr_data_out SHALL be combinational: status word when csr_enable=1 and csr_addr==STATUS_ADDR, else 0.
REQ-027 Accesses to other CSR addresses SHALL have no effect.

Reset
REQ-028 reset_ni=0 SHALL asynchronously clear pointers, count, and overflow flag; have_next=0, full=0, count=0, csr_data_out per REQ-026.
REQ-029 Storage contents SHALL NOT be reset; data is don't-care while have_next=0.
REQ-030 Reset asserted mid-stream SHALL discard all entries; first push after release SHALL appear at data.

Configuration
REQ-031 Macro FIFO_CSR_STATUS_EN defined: status word = {overflow, 15'b0, full, have_next, 14'b0} with count in bits [10:0] (upper count bits truncated above 1024); overflow is sticky, set by REQ-023 drop, cleared by CSRRC/CSRRCI to STATUS_ADDR with bit 31 of the clear mask set (rs1_data[31] for CSRRC; CSRRCI cannot reach bit 31 and SHALL NOT clear).
REQ-032 Macro FIFO_CSR_STATUS_EN undefined: no overflow register, status word = 0, STATUS_ADDR accesses ignored.

Verification
REQ-033 DATA_W=8, DEPTH=4: CSRRW 'h13,'h37,'hDE,'hAD consecutive -> count=4, full=1, data='h13; three pops -> data 'h37,'hDE,'hAD in order.
REQ-034 Fill DEPTH=4, push 'h55 without pop -> dropped, count=4, status bit31=1 (STATUS_EN); CSRRC rs1_data='h8000_0000 to STATUS_ADDR -> bit31=0.
REQ-035 Full, push 'h99 with next=1 same cycle -> count stays 4, 'h99 popped last after 3 remaining entries.
REQ-036 Empty, push 'hA5 with next=1 -> count=1, have_next=1, data='hA5 next cycle.
REQ-037 Push/pop 10 entries through DEPTH=4 -> pointer wrap, data order preserved, count returns 0; CSRRWI rs1_zimm=5'h1F -> data='h1F.
REQ-038 Three entries queued, reset_ni low mid-cycle -> have_next=0, count=0 immediately without clock edge.
